// File: rtl/aes_pkg.sv
// Shared types and widths for the AES block loader slice.
package aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_NWORDS = AES_BLK_W / AES_WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LOAD,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/aes_word_pack.sv
// 4x32 <-> 128 slot mux/demux; slot 0 is bits [127:96].
module aes_word_pack
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0]  wr_blk,
  input  logic [1:0]            wr_sel,
  input  logic [AES_WORD_W-1:0] wr_word,
  output logic [AES_BLK_W-1:0]  wr_blk_new,
  input  logic [AES_BLK_W-1:0]  rd_blk,
  input  logic [1:0]            rd_sel,
  output logic [AES_WORD_W-1:0] rd_word
);

  // Replace one slot of wr_blk and select one slot of rd_blk.
  always_comb begin
    wr_blk_new = wr_blk;
    rd_word    = '0;
    for (int unsigned i = 0; i < AES_NWORDS; i++) begin
      if (wr_sel == i[1:0]) begin
        wr_blk_new[AES_BLK_W-1-AES_WORD_W*i -: AES_WORD_W] = wr_word;
      end
      if (rd_sel == i[1:0]) begin
        rd_word = rd_blk[AES_BLK_W-1-AES_WORD_W*i -: AES_WORD_W];
      end
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Feeds plaintext/key to aes_cipher_top, pulses ld, waits for done and
// streams the 128-bit result back as four big-endian 32-bit words.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  key_we,
  input  logic [1:0]            key_addr,
  input  logic [AES_WORD_W-1:0] key_wdata,
  output logic                  key_busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AES_WORD_W-1:0] m_data,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  core_ld,
  output logic [AES_BLK_W-1:0]  core_key,
  output logic [AES_BLK_W-1:0]  core_text,
  input  logic                  core_done,
  input  logic [AES_BLK_W-1:0]  core_out
);

  state_e                 state_q, state_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic [1:0]             ocnt_q, ocnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   err_q, err_d;
  logic                   done_q;
  logic [AES_BLK_W-1:0]   core_key_q, core_key_d;
  logic [AES_BLK_W-1:0]   core_text_q, core_text_d;
  logic [AES_BLK_W-1:0]   result_q, result_d;
  logic [AES_BLK_W-1:0]   text_packed;
  logic                   s_hs, m_hs, done_edge;

  assign s_ready   = (state_q == IDLE) || (state_q == COLLECT);
  assign key_busy  = (state_q == LOAD) || (state_q == WAIT);
  assign m_valid   = (state_q == OUT);
  assign core_ld   = (state_q == LOAD);
  assign err       = err_q;
  assign core_key  = core_key_q;
  assign core_text = core_text_q;

  assign s_hs      = s_valid & s_ready;
  assign m_hs      = m_valid & m_ready;
  assign done_edge = core_done & ~done_q;

  aes_word_pack u_pack (
    .wr_blk     (core_text_q),
    .wr_sel     (wcnt_q),
    .wr_word    (s_data),
    .wr_blk_new (text_packed),
    .rd_blk     (result_q),
    .rd_sel     (ocnt_q),
    .rd_word    (m_data)
  );

  // Next-state and datapath update for the loader FSM.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ocnt_d      = ocnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    core_key_d  = core_key_q;
    core_text_d = core_text_q;
    result_d    = result_q;

    if (key_we && !key_busy) begin
      case (key_addr)
        2'd0:    core_key_d[127:96] = key_wdata;
        2'd1:    core_key_d[95:64]  = key_wdata;
        2'd2:    core_key_d[63:32]  = key_wdata;
        default: core_key_d[31:0]   = key_wdata;
      endcase
    end

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE, COLLECT: begin
        if (s_hs) begin
          core_text_d = text_packed;
          wcnt_d      = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d  = LOAD;
            to_cnt_d = '0;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      LOAD: begin
        // The ld cycle is counted so the abort lands TIMEOUT_CYC cycles after core_ld.
        to_cnt_d = to_cnt_q + 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          result_d = core_out;
          state_d  = OUT;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (m_hs) begin
          ocnt_d = ocnt_q + 2'd1;
          if (ocnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all loader state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      core_key_q  <= '0;
      core_text_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ocnt_q      <= ocnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      done_q      <= core_done;
      core_key_q  <= core_key_d;
      core_text_q <= core_text_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader with an XOR core stub.
module tb_aes_block_loader;

  localparam int TO_CYC = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         key_we = 1'b0;
  logic [1:0]   key_addr = '0;
  logic [31:0]  key_wdata = '0;
  logic         key_busy;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         err;
  logic         err_clr = 1'b0;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ld_cnt   = 0;

  // Stub control
  logic stub_en    = 1'b1;
  logic stub_clear = 1'b0;
  logic done_force = 1'b0;
  logic stub_done  = 1'b0;
  logic stub_armed = 1'b0;
  int   stub_cnt   = 0;

  // Reference model state
  logic [31:0] mkey [4];
  logic [31:0] pt   [4];
  logic [31:0] exp_w[$];

  always #5 clk = ~clk;

  aes_block_loader #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata), .key_busy(key_busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err), .err_clr(err_clr),
    .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_out(core_out)
  );

  // Core stub: done rises 12 cycles after ld, held until the next ld.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stub_clear) begin
      stub_done  <= 1'b0;
      stub_armed <= 1'b0;
    end else if (core_ld) begin
      stub_done  <= 1'b0;
      stub_armed <= 1'b1;
      stub_cnt   <= 1;
    end else if (stub_armed && stub_en) begin
      if (stub_cnt == 11) begin
        stub_done  <= 1'b1;
        stub_armed <= 1'b0;
      end
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign core_done = stub_done | done_force;
  assign core_out  = core_text ^ core_key;

  always @(negedge clk) if (core_ld) ld_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] key_blk();
    return {mkey[0], mkey[1], mkey[2], mkey[3]};
  endfunction

  function automatic logic [127:0] pt_blk();
    return {pt[0], pt[1], pt[2], pt[3]};
  endfunction

  task automatic write_key(input logic [1:0] a, input logic [31:0] d);
    key_we = 1'b1; key_addr = a; key_wdata = d;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  // Present one word; returns at the negedge after its handshake. s_valid stays high.
  task automatic send_word(input logic [31:0] d);
    int t = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && t < 300) begin
      @(negedge clk); t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_block();
    for (int i = 0; i < 4; i++) send_word(pt[i]);
    s_valid = 1'b0;
  endtask

  task automatic queue_expected();
    for (int i = 0; i < 4; i++) exp_w.push_back(pt[i] ^ mkey[i]);
  endtask

  // Receive n words against exp_w, optionally with random m_ready stalls.
  task automatic recv_words(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [31:0] e;
      m_ready = 1'b0;
      while (!(m_valid && (!stall || $urandom_range(0, 2) != 0)) && t < 500) begin
        @(negedge clk); t++;
      end
      e = (exp_w.size() > 0) ? exp_w.pop_front() : 32'h0;
      if (!m_valid) begin
        chk("m_valid_timeout", 0, 1);
      end else begin
        chk("m_data", m_data, e);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int c0, t, ld0;
    bit saw_mv;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_core_ld", core_ld, 0);
    chk("rst_key_busy", key_busy, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_text", core_text, 0);

    // 1: directed vector
    mkey = '{32'hCAFEBABE, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    for (int i = 0; i < 4; i++) write_key(2'(i), mkey[i]);
    chk("t1_core_key", core_key, key_blk());
    pt = '{32'hE5E9186F, 32'hA7294696, 32'h97547738, 32'hA3E2ABF5};
    ld0 = ld_cnt;
    send_block();
    chk("t1_ld_after_4th", core_ld, 1);
    chk("t1_core_text", core_text, pt_blk());
    queue_expected();
    recv_words(4, 0);
    chk("t1_ld_count", ld_cnt - ld0, 1);
    chk("t1_idle_s_ready", s_ready, 1);

    // 2: stall at ocnt=2
    send_block();
    queue_expected();
    recv_words(2, 0);
    t = 0;
    while (!m_valid && t < 100) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_data", m_data, exp_w[0]);
      chk("t2_hold_s_ready", s_ready, 0);
      @(negedge clk);
    end
    recv_words(2, 0);

    // 3: timeout, then err_clr
    stub_en = 1'b0;
    send_block();
    c0 = cyc;
    saw_mv = 0;
    t = 0;
    while (!err && t < 200) begin
      @(negedge clk); t++;
      if (m_valid) saw_mv = 1;
    end
    chk("t3_err_latency", cyc - c0, TO_CYC);
    chk("t3_no_m_valid", saw_mv, 0);
    chk("t3_s_ready_back", s_ready, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_err_cleared", err, 0);
    // err_clr held across a timeout: the set takes priority that cycle.
    err_clr = 1'b1;
    send_block();
    t = 0;
    while (key_busy && t < 200) begin @(negedge clk); t++; end
    chk("t3_set_wins", err, 1);
    @(negedge clk);
    chk("t3_clr_after", err, 0);
    err_clr = 1'b0;
    stub_clear = 1'b1; @(negedge clk); stub_clear = 1'b0;
    stub_en = 1'b1;

    // 4: key write dropped in WAIT, accepted in IDLE
    for (int i = 0; i < 4; i++) pt[i] = $urandom;
    send_block();
    @(negedge clk);
    write_key(2'd0, 32'hFFFFFFFF);
    chk("t4_busy", key_busy, 1);
    chk("t4_key_unchanged", core_key, key_blk());
    queue_expected();
    recv_words(4, 1);
    write_key(2'd0, 32'hFFFFFFFF);
    mkey[0] = 32'hFFFFFFFF;
    chk("t4_key_idle", core_key[127:96], 32'hFFFFFFFF);

    // 5: reset mid-collect, stale done edge, key write with 4th word
    stub_clear = 1'b1; @(negedge clk); stub_clear = 1'b0;
    send_word(32'h11111111);
    send_word(32'h22222222);
    s_valid = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    done_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_m_valid", m_valid, 0);
      chk("t5_idle", s_ready, 1);
    end
    done_force = 1'b0;
    @(negedge clk);
    chk("t5_key_after_rst", core_key, 0);
    mkey = '{default: 32'h0};
    for (int i = 0; i < 4; i++) pt[i] = $urandom;
    for (int i = 0; i < 3; i++) send_word(pt[i]);
    key_we = 1'b1; key_addr = 2'd3; key_wdata = $urandom;
    mkey[3] = key_wdata;
    send_word(pt[3]);
    key_we = 1'b0; s_valid = 1'b0;
    chk("t5_ld", core_ld, 1);
    chk("t5_text_slot0", core_text, pt_blk());
    chk("t5_key_before_ld", core_key, key_blk());
    queue_expected();
    recv_words(4, 1);

    // 6: back-to-back blocks with s_valid held high, random keys
    for (int r = 0; r < 3; r++) begin
      logic [31:0] words[8];
      for (int i = 0; i < 4; i++) begin
        mkey[i] = $urandom;
        write_key(2'(i), mkey[i]);
      end
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      for (int i = 0; i < 8; i++) exp_w.push_back(words[i] ^ mkey[i % 4]);
      ld0 = ld_cnt;
      fork
        begin
          for (int i = 0; i < 8; i++) send_word(words[i]);
          s_valid = 1'b0;
        end
        recv_words(8, 1);
      join
      repeat (2) @(negedge clk);
      chk("t6_ld_count", ld_cnt - ld0, 2);
      chk("t6_idle", s_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
